// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard/stall controller:
// FSM encoding, the x0 register index and the default memory-wait timeout.
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_X0          = 5'd0;
    localparam int         MEM_TIMEOUT_DEF = 200;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard inputs and stall/flush controls of the hazard controller.
// The pipeline drives through master; the controller consumes through slave.
interface hazard_stall_ctrl_if;
    logic [4:0]  ID_Rs1_addr;
    logic [4:0]  ID_Rs2_addr;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic        EX_MemRead;
    logic [4:0]  EX_Rd_addr;
    logic        EX_branch_taken;
    logic        MEM_req;
    logic        MEM_ack;
    logic        PC_stall;
    logic        IF_ID_stall;
    logic        IF_ID_flush;
    logic        ID_EX_stall;
    logic        ID_EX_flush;
    logic        EX_MEM_stall;
    logic        MEM_WB_flush;
    logic        MEM_abort;
    logic        mem_err;
    logic [31:0] stall_cnt;

    modport master (
        output ID_Rs1_addr, ID_Rs2_addr, ID_use_rs1, ID_use_rs2,
               EX_MemRead, EX_Rd_addr, EX_branch_taken, MEM_req, MEM_ack,
        input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, MEM_abort, mem_err, stall_cnt
    );

    modport slave (
        input  ID_Rs1_addr, ID_Rs2_addr, ID_use_rs1, ID_use_rs2,
               EX_MemRead, EX_Rd_addr, EX_branch_taken, MEM_req, MEM_ack,
        output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, MEM_abort, mem_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ldu_detect.sv
// Combinational load-use detector: a load in EX whose rd (non-x0) is read
// by the instruction currently in ID.
module hazard_ldu_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       id_use_rs1_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_use_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_use_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
    assign load_use_o = ex_mem_read_i && (ex_rd_addr_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, EX branch
// flushes and whole-pipe freezes on slow data memory, with a wait timeout.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_ctrl_if.slave pif
);

    hz_state_e         state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic timeout_hit;
    logic mem_hold;
    logic abort;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, mem_wb_flush;

    hazard_ldu_detect u_ldu (
        .ex_mem_read_i (pif.EX_MemRead),
        .ex_rd_addr_i  (pif.EX_Rd_addr),
        .id_use_rs1_i  (pif.ID_use_rs1),
        .id_rs1_addr_i (pif.ID_Rs1_addr),
        .id_use_rs2_i  (pif.ID_use_rs2),
        .id_rs2_addr_i (pif.ID_Rs2_addr),
        .load_use_o    (load_use)
    );

    assign timeout_hit = (state_q == MEM_WAIT) && (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
    // A same-cycle ack beats the timeout, so abort needs ~MEM_ack as well.
    assign mem_hold    = pif.MEM_req && !pif.MEM_ack && !timeout_hit;
    assign abort       = timeout_hit && pif.MEM_req && !pif.MEM_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d      = RUN;
        to_cnt_d     = '0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (mem_hold) begin
            // Freeze everything up to MEM; EX hazards are re-evaluated after the hold.
            state_d      = MEM_WAIT;
            to_cnt_d     = (state_q == MEM_WAIT) ? to_cnt_q + TO_W'(1) : '0;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            mem_wb_flush = abort;
            if (pif.EX_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
        mem_err_d   = mem_err_q || abort;
        stall_cnt_d = stall_cnt_q + 32'(pc_stall);
    end

    // Controls are forced low for as long as reset is held.
    assign pif.PC_stall     = rst_n && pc_stall;
    assign pif.IF_ID_stall  = rst_n && if_id_stall;
    assign pif.IF_ID_flush  = rst_n && if_id_flush;
    assign pif.ID_EX_stall  = rst_n && id_ex_stall;
    assign pif.ID_EX_flush  = rst_n && id_ex_flush;
    assign pif.EX_MEM_stall = rst_n && ex_mem_stall;
    assign pif.MEM_WB_flush = rst_n && mem_wb_flush;
    assign pif.MEM_abort    = rst_n && abort;
    assign pif.mem_err      = mem_err_q;
    assign pif.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a
// randomized run against a cycle-level model of the hazard rules.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;
    localparam int TO = 4;

    // Control vector order: PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
    // ID_EX_flush, EX_MEM_stall, MEM_WB_flush, MEM_abort
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_HOLD  = 8'b1101_0110;
    localparam logic [7:0] C_LDU   = 8'b1100_1000;
    localparam logic [7:0] C_BR    = 8'b0010_1000;
    localparam logic [7:0] C_ABORT = 8'b0000_0011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    hazard_stall_ctrl_if pif ();

    hazard_stall_ctrl #(.TO_W(8), .MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctl();
        return {pif.PC_stall, pif.IF_ID_stall, pif.IF_ID_flush, pif.ID_EX_stall,
                pif.ID_EX_flush, pif.EX_MEM_stall, pif.MEM_WB_flush, pif.MEM_abort};
    endfunction

    task automatic idle();
        pif.ID_Rs1_addr = 5'd0; pif.ID_Rs2_addr = 5'd0;
        pif.ID_use_rs1 = 1'b0;  pif.ID_use_rs2 = 1'b0;
        pif.EX_MemRead = 1'b0;  pif.EX_Rd_addr = 5'd0;
        pif.EX_branch_taken = 1'b0;
        pif.MEM_req = 1'b0;     pif.MEM_ack = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        pif.MEM_req = 1'b1;
        pif.EX_branch_taken = 1'b1;
        #3;
        checks++;
        if (ctl() !== C_NONE) $display("FAIL reset_ctl actual=%b required=%b", ctl(), C_NONE);
        else passes++;
        checks++;
        if (pif.stall_cnt !== 32'd0 || pif.mem_err !== 1'b0)
            $display("FAIL reset_regs stall_cnt=%0d mem_err=%b required 0/0", pif.stall_cnt, pif.mem_err);
        else passes++;
        $display("reset: ctl=%b stall_cnt=%0d mem_err=%b", ctl(), pif.stall_cnt, pif.mem_err);
        do_reset();
    endtask

    task automatic test_load_use();
        logic [31:0] base;
        idle();
        base = pif.stall_cnt;
        pif.EX_MemRead = 1'b1; pif.EX_Rd_addr = 5'd5;
        pif.ID_use_rs1 = 1'b1; pif.ID_Rs1_addr = 5'd5; pif.ID_Rs2_addr = 5'd1;
        #3;
        checks++;
        if (ctl() !== C_LDU) $display("FAIL load_use_stall actual=%b required=%b", ctl(), C_LDU);
        else passes++;
        $display("load_use lw x5 / add x6,x5,x1: ctl=%b", ctl());
        step();
        pif.EX_MemRead = 1'b0; pif.EX_Rd_addr = 5'd0;
        #3;
        checks++;
        if (ctl() !== C_NONE || pif.stall_cnt !== base + 32'd1)
            $display("FAIL load_use_release ctl=%b stall_cnt=%0d required=%b/%0d", ctl(), pif.stall_cnt, C_NONE, base + 32'd1);
        else passes++;
        $display("load_use bubble cycle: ctl=%b stall_cnt=%0d", ctl(), pif.stall_cnt);
        step();
        pif.EX_MemRead = 1'b1; pif.EX_Rd_addr = 5'd0; pif.ID_Rs1_addr = 5'd0;
        #3;
        checks++;
        if (ctl() !== C_NONE) $display("FAIL load_use_x0 actual=%b required=%b", ctl(), C_NONE);
        else passes++;
        $display("load_use rd=x0: ctl=%b", ctl());
        step();
        idle();
        pif.EX_MemRead = 1'b1; pif.EX_Rd_addr = 5'd9;
        pif.ID_use_rs2 = 1'b1; pif.ID_Rs2_addr = 5'd9;
        #3;
        checks++;
        if (ctl() !== C_LDU) $display("FAIL load_use_rs2 actual=%b required=%b", ctl(), C_LDU);
        else passes++;
        $display("load_use via rs2: ctl=%b", ctl());
        step();
        idle();
    endtask

    task automatic test_branch_priority();
        pif.EX_MemRead = 1'b1; pif.EX_Rd_addr = 5'd5;
        pif.ID_use_rs1 = 1'b1; pif.ID_Rs1_addr = 5'd5;
        pif.EX_branch_taken = 1'b1;
        #3;
        checks++;
        if (ctl() !== C_BR) $display("FAIL branch_over_ldu actual=%b required=%b", ctl(), C_BR);
        else passes++;
        $display("branch + load_use: ctl=%b", ctl());
        step();
        idle();
    endtask

    task automatic test_mem_wait();
        logic [31:0] base;
        base = pif.stall_cnt;
        pif.MEM_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            pif.EX_branch_taken = (c == 2);
            #3;
            checks++;
            if (ctl() !== C_HOLD) $display("FAIL mem_wait_hold c%0d actual=%b required=%b", c, ctl(), C_HOLD);
            else passes++;
            $display("mem_wait cycle %0d: ctl=%b", c, ctl());
            step();
        end
        pif.EX_branch_taken = 1'b0;
        pif.MEM_ack = 1'b1;
        #3;
        checks++;
        if (ctl() !== C_NONE) $display("FAIL mem_wait_ack actual=%b required=%b", ctl(), C_NONE);
        else passes++;
        step();
        idle();
        #3;
        checks++;
        if (pif.stall_cnt !== base + 32'd3) $display("FAIL mem_wait_cnt actual=%0d required=%0d", pif.stall_cnt, base + 32'd3);
        else passes++;
        $display("mem_wait ack: stall_cnt=%0d", pif.stall_cnt);
        step();
        pif.MEM_req = 1'b1; pif.MEM_ack = 1'b1;
        #3;
        checks++;
        if (ctl() !== C_NONE) $display("FAIL mem_zero_wait actual=%b required=%b", ctl(), C_NONE);
        else passes++;
        $display("mem immediate ack: ctl=%b", ctl());
        step();
        idle();
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        pif.MEM_req = 1'b1;
        for (int c = 1; c <= TO; c++) begin
            #3;
            checks++;
            if (ctl() !== C_HOLD) $display("FAIL ack_to_hold c%0d actual=%b required=%b", c, ctl(), C_HOLD);
            else passes++;
            step();
        end
        pif.MEM_ack = 1'b1;
        #3;
        checks++;
        if (ctl() !== C_NONE) $display("FAIL ack_at_timeout actual=%b required=%b", ctl(), C_NONE);
        else passes++;
        step();
        idle();
        #3;
        checks++;
        if (pif.mem_err !== 1'b0) $display("FAIL ack_to_err actual=%b required=0", pif.mem_err);
        else passes++;
        $display("ack at timeout: ctl=%b mem_err=%b", ctl(), pif.mem_err);
        step();
    endtask

    task automatic test_timeout();
        pif.MEM_req = 1'b1;
        for (int c = 1; c <= TO; c++) begin
            #3;
            checks++;
            if (ctl() !== C_HOLD) $display("FAIL timeout_hold c%0d actual=%b required=%b", c, ctl(), C_HOLD);
            else passes++;
            step();
        end
        pif.EX_branch_taken = 1'b1;
        #3;
        checks++;
        if (ctl() !== (C_ABORT | C_BR) || pif.mem_err !== 1'b0)
            $display("FAIL timeout_abort ctl=%b mem_err=%b required=%b/0", ctl(), pif.mem_err, C_ABORT | C_BR);
        else passes++;
        $display("timeout abort cycle: ctl=%b", ctl());
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            #3;
            checks++;
            if (pif.mem_err !== 1'b1 || ctl() !== C_NONE)
                $display("FAIL timeout_err c%0d mem_err=%b ctl=%b required=1/%b", c, pif.mem_err, ctl(), C_NONE);
            else passes++;
            step();
        end
        $display("timeout: mem_err=%b sticky", pif.mem_err);
    endtask

    task automatic test_reset_mid_wait();
        pif.MEM_req = 1'b1;
        #3;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl() !== C_NONE || pif.stall_cnt !== 32'd0 || pif.mem_err !== 1'b0)
            $display("FAIL reset_mid_wait ctl=%b stall_cnt=%0d mem_err=%b required all 0", ctl(), pif.stall_cnt, pif.mem_err);
        else passes++;
        $display("reset mid-wait: ctl=%b stall_cnt=%0d", ctl(), pif.stall_cnt);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        #3;
        checks++;
        if (ctl() !== C_NONE) $display("FAIL post_reset_idle actual=%b required=%b", ctl(), C_NONE);
        else passes++;
        step();
        pif.MEM_req = 1'b1; pif.MEM_ack = 1'b1;
        #3;
        checks++;
        if (ctl() !== C_NONE || pif.stall_cnt !== 32'd0)
            $display("FAIL post_reset_run ctl=%b stall_cnt=%0d required=%b/0", ctl(), pif.stall_cnt, C_NONE);
        else passes++;
        step();
        idle();
    endtask

    // Model: count consecutive held request cycles; the request is abandoned
    // when the count reaches the timeout and no ack arrives.
    task automatic test_random();
        int          waited = 0;
        bit          err = 1'b0;
        logic [31:0] cnt = 32'd0;
        logic [7:0]  exp;
        bit          hit, hold, lu;
        int          bad;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pif.ID_Rs1_addr = 5'($urandom_range(0, 3));
            pif.ID_Rs2_addr = 5'($urandom_range(0, 3));
            pif.ID_use_rs1 = 1'($urandom_range(0, 1));
            pif.ID_use_rs2 = 1'($urandom_range(0, 1));
            pif.EX_MemRead = 1'($urandom_range(0, 1));
            pif.EX_Rd_addr = 5'($urandom_range(0, 3));
            pif.EX_branch_taken = ($urandom_range(0, 4) == 0);
            pif.MEM_req = ($urandom_range(0, 9) < 6);
            pif.MEM_ack = ($urandom_range(0, 9) < 3);
            #3;
            hit  = pif.MEM_req && !pif.MEM_ack && (waited == TO);
            hold = pif.MEM_req && !pif.MEM_ack && !hit;
            lu   = pif.EX_MemRead && (pif.EX_Rd_addr != 5'd0) &&
                   ((pif.ID_use_rs1 && pif.ID_Rs1_addr == pif.EX_Rd_addr) ||
                    (pif.ID_use_rs2 && pif.ID_Rs2_addr == pif.EX_Rd_addr));
            if (hold) exp = C_HOLD;
            else exp = (hit ? C_ABORT : C_NONE) | (pif.EX_branch_taken ? C_BR : (lu ? C_LDU : C_NONE));
            checks++;
            bad = 0;
            if (ctl() !== exp || pif.stall_cnt !== cnt || pif.mem_err !== err) begin
                bad = 1;
                $display("FAIL random n%0d ctl=%b cnt=%0d err=%b required=%b/%0d/%b", n, ctl(), pif.stall_cnt, pif.mem_err, exp, cnt, err);
            end else passes++;
            if (bad == 0) $display("random n%0d: req=%b ack=%b ctl=%b cnt=%0d", n, pif.MEM_req, pif.MEM_ack, ctl(), cnt);
            cnt    = cnt + 32'(exp[7]);
            err    = err | hit;
            waited = hold ? waited + 1 : 0;
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
